// File: rtl/reg_bank_pkg.sv
// Shared definitions for the arbitrated register bank: FunSel encodings and arbiter states.
package reg_bank_pkg;

  localparam logic [1:0] FS_CLEAR = 2'b00;
  localparam logic [1:0] FS_LOAD  = 2'b01;
  localparam logic [1:0] FS_DEC   = 2'b10;
  localparam logic [1:0] FS_INC   = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/reg_cell.sv
// One bank register applying a FunSel op when enabled; q_next exposes the value the op
// would produce so the response path can capture it without recomputing.
module reg_cell
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       funsel,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (funsel)
      FS_CLEAR: q_next = '0;
      FS_LOAD:  q_next = load_data;
      FS_DEC:   q_next = q - WIDTH'(1);
      default:  q_next = q + WIDTH'(1);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by NUM_REQ requesters with round-robin grant and locked sequences.
//   state      | meaning
//   ST_IDLE    | grant first valid requester at or after rr_ptr
//   ST_LOCKED  | only owner_q may be granted; its unlocking op returns to ST_IDLE
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int NUM_REGS = 4,
  parameter int NUM_REQ  = 2,
  parameter int SW       = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [2*NUM_REQ-1:0]      req_funsel,
  input  logic [SW*NUM_REQ-1:0]     req_sel,
  input  logic [WIDTH*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [WIDTH-1:0]          rsp_data,
  output logic [WIDTH*NUM_REGS-1:0] regs_out
);

  localparam int PW = $clog2(NUM_REQ);

  arb_state_e       state_q, state_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    cand;
  logic [PW-1:0]    gnt_idx;
  logic             found;
  logic             xfer;

  logic [1:0]       funsel_g;
  logic [SW-1:0]    sel_g;
  logic [WIDTH-1:0] data_g;

  logic [NUM_REGS-1:0] cell_en;
  logic [WIDTH-1:0]    cell_q    [NUM_REGS];
  logic [WIDTH-1:0]    cell_next [NUM_REGS];

  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [WIDTH-1:0]   rsp_data_q;

  // Ready is held low during reset so nothing looks accepted while state is being cleared.
  always_comb begin
    req_ready = '0;
    found     = 1'b0;
    cand      = '0;
    if (!rst) begin
      if (state_q == ST_IDLE) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          cand = PW'((int'(rr_ptr_q) + k) % NUM_REQ);
          if (!found && req_valid[cand]) begin
            req_ready[cand] = 1'b1;
            found           = 1'b1;
          end
        end
      end else begin
        req_ready[owner_q] = req_valid[owner_q];
      end
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) gnt_idx = PW'(i);
    end
  end

  assign xfer     = |(req_valid & req_ready);
  assign funsel_g = req_funsel[gnt_idx*2 +: 2];
  assign sel_g    = req_sel[gnt_idx*SW +: SW];
  assign data_g   = req_data[gnt_idx*WIDTH +: WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // While locked the granted index is always the owner, so rr_ptr keeps owner+1.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + PW'(1);
      if (req_lock[gnt_idx]) begin
        state_d = ST_LOCKED;
        owner_d = gnt_idx;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cell
    assign cell_en[r] = xfer && (sel_g == SW'(r));

    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk       (clk),
      .rst       (rst),
      .en        (cell_en[r]),
      .funsel    (funsel_g),
      .load_data (data_g),
      .q         (cell_q[r]),
      .q_next    (cell_next[r])
    );

    assign regs_out[r*WIDTH +: WIDTH] = cell_q[r];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= req_valid & req_ready;
      if (xfer) rsp_data_q <= cell_next[sel_g];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule
